// File: rtl/serial_add2_ctrl_if.sv
// rtl/serial_add2_ctrl_if.sv - request/result bundle for serial_add2_ctrl (ovf only with SERIAL_ADD2_OVF_EN)
interface serial_add2_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD2_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add2_ctrl.sv
// rtl/serial_add2_ctrl.sv - digit-serial adder sequencer on one 2-bit slice; SERIAL_ADD2_OVF_EN adds ovf
module serial_add2_ctrl #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    serial_add2_ctrl_if.slave bus
);
    localparam int DIGITS = WIDTH / 2;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic [2:0]       slice;
    logic [WIDTH+1:0] sum_cat;
    logic             last;

    assign slice   = {1'b0, a_sh[1:0]} + {1'b0, b_sh[1:0]} + {2'b00, carry};
    assign sum_cat = {slice[1:0], sum_r};
    assign last    = (cnt == CW'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef SERIAL_ADD2_OVF_EN
    logic ovf_r;
    logic c_mid;

    // carry from bit WIDTH-2 into bit WIDTH-1, meaningful on the final digit
    assign c_mid = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            ovf_r <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_r <= slice[2] ^ c_mid;
        end
    end

    assign bus.ovf = ovf_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                    end
                end
                RUN: begin
                    // least-significant digit first; finished digits enter at the top
                    a_sh  <= a_sh >> 2;
                    b_sh  <= b_sh >> 2;
                    carry <= slice[2];
                    cnt   <= cnt + 1'b1;
                    sum_r <= sum_cat[WIDTH+1:2];
                    if (last) cout_r <= slice[2];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_add2_ctrl.sv
// tb/tb_serial_add2_ctrl.sv - randomized self-checking bench for serial_add2_ctrl (SERIAL_ADD2_OVF_EN aware)
module tb_serial_add2_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    serial_add2_ctrl_if #(.WIDTH(W)) intf ();

    serial_add2_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return W'(0) + {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
    endfunction

    function automatic logic get_ovf();
`ifdef SERIAL_ADD2_OVF_EN
        return intf.ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         output int lat, output int busy_cnt,
                         output logic [W-1:0] rs, output logic rc, output logic ro,
                         output logic [W-1:0] held);
        @(negedge clk);
        intf.start = 1'b1; intf.a = ta; intf.b = tb_v; intf.cin = tc;
        @(posedge clk);
        @(negedge clk);
        intf.start = 1'b0; intf.a = W'($urandom); intf.b = W'($urandom); intf.cin = 1'($urandom);
        lat = 0;
        busy_cnt = intf.busy ? 1 : 0;
        while (!intf.done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (intf.busy) busy_cnt++;
        end
        rs = intf.sum; rc = intf.cout; ro = get_ovf();
        @(posedge clk);
        @(negedge clk);
        if (intf.busy) busy_cnt++;
        held = intf.sum;
    endtask

    task automatic test_reset();
        intf.start = 1'b0; intf.a = '0; intf.b = '0; intf.cin = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (intf.busy !== 1'b0 || intf.done !== 1'b0 || intf.sum !== '0 || intf.cout !== 1'b0 || get_ovf() !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
                     intf.busy, intf.done, intf.sum, intf.cout, get_ovf());
        end
        rst_n = 1'b1;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
        int lat, bc;
        logic [W-1:0] rs, held;
        logic rc, ro;
        logic [W:0] e;
        e = ref_sum(ta, tb_v, tc);
        do_op(ta, tb_v, tc, lat, bc, rs, rc, ro, held);
        checks++;
        if (lat !== W / 2) begin
            errors++; $display("FAIL %s latency got %0d required %0d", name, lat, W / 2);
        end
        checks++;
        if ({rc, rs} !== e) begin
            errors++; $display("FAIL %s result a=%h b=%h cin=%b got cout=%b sum=%h required cout=%b sum=%h",
                               name, ta, tb_v, tc, rc, rs, e[W], e[W-1:0]);
        end
        checks++;
        if (bc !== W / 2 + 1) begin
            errors++; $display("FAIL %s busy_cycles got %0d required %0d", name, bc, W / 2 + 1);
        end
        checks++;
        if (held !== e[W-1:0] || intf.done !== 1'b0) begin
            errors++; $display("FAIL %s hold sum=%h done=%b required sum=%h done=0", name, held, intf.done, e[W-1:0]);
        end
`ifdef SERIAL_ADD2_OVF_EN
        checks++;
        if (ro !== ref_ovf(ta, tb_v, tc)) begin
            errors++; $display("FAIL %s ovf got %b required %b", name, ro, ref_ovf(ta, tb_v, tc));
        end
`endif
    endtask

    task automatic test_directed();
        check_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0);
        check_op("ff_plus_01", 8'hFF, 8'h01, 1'b0);
        check_op("ff_plus_cin", 8'hFF, 8'h00, 1'b1);
        check_op("ff_ff_cin", 8'hFF, 8'hFF, 1'b1);
        check_op("zero", 8'h00, 8'h00, 1'b0);
        check_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0);
        check_op("ovf_80_80", 8'h80, 8'h80, 1'b0);
        check_op("no_ovf_40_20", 8'h40, 8'h20, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            check_op("random", W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic test_back_to_back();
        int last_done = -1;
        int n_done = 0;
        int guard;
        @(negedge clk);
        intf.start = 1'b1; intf.a = 8'h11; intf.b = 8'h22; intf.cin = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (intf.done) begin
                n_done++;
                checks++;
                if (intf.sum !== 8'h33 || intf.cout !== 1'b0) begin
                    errors++; $display("FAIL b2b_result cycle %0d got cout=%b sum=%h required cout=0 sum=33", i, intf.cout, intf.sum);
                end
                if (last_done >= 0) begin
                    checks++;
                    if (i - last_done !== W / 2 + 2) begin
                        errors++; $display("FAIL b2b_period got %0d required %0d", i - last_done, W / 2 + 2);
                    end
                end
                last_done = i;
            end
            if (intf.busy) begin
                intf.a = W'($urandom); intf.b = W'($urandom); intf.cin = 1'($urandom);
            end else begin
                intf.a = 8'h11; intf.b = 8'h22; intf.cin = 1'b0;
            end
        end
        checks++;
        if (n_done !== 6) begin
            errors++; $display("FAIL b2b_count got %0d required 6", n_done);
        end
        intf.start = 1'b0;
        guard = 0;
        while (intf.busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (intf.busy !== 1'b0) begin
            errors++; $display("FAIL b2b_drain busy=%b required 0 within 20 cycles", intf.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        intf.start = 1'b1; intf.a = 8'hA7; intf.b = 8'h6D; intf.cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        intf.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (intf.busy !== 1'b0 || intf.done !== 1'b0 || intf.sum !== '0 || intf.cout !== 1'b0 || get_ovf() !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
                     intf.busy, intf.done, intf.sum, intf.cout, get_ovf());
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_op("after_reset", W'($urandom), W'($urandom), 1'($urandom));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
